// File: rtl/program_loader.sv
// program_loader: boot-time instruction-memory writer.
// Receives a framed byte stream (length, 16-bit words, XOR checksum) and
// writes each word into instruction memory while holding the CPU off.
//
// Byte handshake: a byte transfers on a rising clk edge where
// rx_valid & rx_ready are both 1. The sender holds rx_data stable while
// rx_valid is high. rx_ready is a registered decode of the FSM state, so
// holding rx_valid high outside a frame consumes nothing.
module program_loader #(
  parameter int IMEM_DEPTH = 4096,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [11:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } loaderStateT;

  localparam logic [15:0] MAX_LEN      = 16'(IMEM_DEPTH);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  loaderStateT state;
  loaderStateT nextState;

  logic [7:0]  lenHi;
  logic [15:0] wordCount;
  logic [15:0] wordIdx;
  logic [7:0]  hiByte;
  logic [7:0]  chkAcc;
  logic [15:0] idleCount;

  logic        accept;
  logic        inFrame;
  logic        nextInFrame;
  logic        armed;
  logic        writeNow;
  logic        lenOk;
  logic        lastWord;
  logic        timedOut;
  logic [15:0] lenValue;

  assign accept      = rx_valid & rx_ready;
  assign inFrame     = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  assign nextInFrame = nextState inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  assign armed       = start && (state inside {IDLE, DONE, ERR});
  assign writeNow    = accept && (state == DATA_LO);
  assign lenValue    = {lenHi, rx_data};
  assign lenOk       = (lenValue != 16'd0) && (lenValue <= MAX_LEN);
  assign lastWord    = (wordIdx + 16'd1) >= wordCount;
  // An accepted byte in the final idle cycle wins over the timeout.
  assign timedOut    = inFrame && !accept && (idleCount == TIMEOUT_LAST);
  assign dbgState    = state;

  // Next-state decode; start is only honoured outside a frame.
  always_comb begin
    nextState = state;
    if (timedOut) begin
      nextState = ERR;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) nextState = LEN_HI;
        LEN_HI:  if (accept) nextState = LEN_LO;
        LEN_LO:  if (accept) nextState = lenOk ? DATA_HI : ERR;
        DATA_HI: if (accept) nextState = DATA_LO;
        DATA_LO: if (accept) nextState = lastWord ? CHECK : DATA_HI;
        CHECK:   if (accept) nextState = (rx_data == chkAcc) ? DONE : ERR;
        default: nextState = IDLE;
      endcase
    end
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= 12'd0;
      imem_wdata <= 16'd0;
    end else begin
      state    <= nextState;
      rx_ready <= nextInFrame;
      busy     <= nextInFrame;
      done     <= (nextState == DONE);
      error    <= (nextState == ERR);
      // Only a verified load ever lets the CPU run.
      cpu_hold <= (nextState != DONE);
      imem_we  <= writeNow;
      if (writeNow) begin
        imem_addr  <= wordIdx[11:0];
        imem_wdata <= {hiByte, rx_data};
      end
    end
  end

  // Frame datapath: length capture, word assembly, checksum, idle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lenHi     <= 8'd0;
      wordCount <= 16'd0;
      wordIdx   <= 16'd0;
      hiByte    <= 8'd0;
      chkAcc    <= 8'd0;
      idleCount <= 16'd0;
    end else if (armed) begin
      chkAcc    <= 8'd0;
      wordIdx   <= 16'd0;
      idleCount <= 16'd0;
    end else if (inFrame) begin
      if (accept) begin
        idleCount <= 16'd0;
        // The checksum byte itself is compared, never accumulated.
        if (state != CHECK) chkAcc <= chkAcc ^ rx_data;
        case (state)
          LEN_HI:  lenHi     <= rx_data;
          LEN_LO:  wordCount <= lenValue;
          DATA_HI: hiByte    <= rx_data;
          DATA_LO: wordIdx   <= wordIdx + 16'd1;
          default: ;
        endcase
      end else begin
        idleCount <= idleCount + 16'd1;
      end
    end
  end

endmodule
